// File: rtl/ice51_loader.sv
// ice51_loader: UART 8N1 program loader that writes MEM_SIZE received bytes into code RAM from address 0
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_uart_rx    asynchronous serial input, idle high
//   o_mem_we     one-cycle program memory write strobe
//   o_mem_addr   write address (holds last written address between writes)
//   o_mem_wdata  write data (holds last written data between writes)
//   o_load_done  sticky, high once MEM_SIZE bytes have been written
//   o_frame_err  one-cycle pulse when a stop bit samples low
//   o_csum       modulo-256 sum of written bytes when ICE51_LOADER_CSUM_EN is defined, else 8'h00
module ice51_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int MEM_SIZE     = 512,
    parameter int ADDR_W       = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_uart_rx,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_load_done,
    output logic              o_frame_err,
    output logic [7:0]        o_csum
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] FULL = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W:0] SIZE = (ADDR_W + 1)'(MEM_SIZE);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;

    state_t            r_state;
    logic [1:0]        r_sync;
    logic [BW-1:0]     r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic [ADDR_W:0]   r_count;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic              r_done;
    logic              r_ferr;
    logic              w_rx;
`ifdef ICE51_LOADER_CSUM_EN
    logic [7:0]        r_csum;
    assign o_csum = r_csum;
`else
    assign o_csum = 8'h00;
`endif

    assign w_rx        = r_sync[1];
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_load_done = r_done;
    assign o_frame_err = r_ferr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_sync  <= 2'b11;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_count <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef ICE51_LOADER_CSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_sync <= {r_sync[0], i_uart_rx};
            r_we   <= 1'b0;
            r_ferr <= 1'b0;
            // count reaches SIZE on the final write edge, so done follows one cycle later
            r_done <= r_done | (r_count == SIZE);
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_state <= ST_START;
                        r_baud  <= '0;
                    end
                end
                ST_START: begin
                    if (r_baud == HALF) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? ST_IDLE : ST_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud == FULL) begin
                        r_baud  <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud == FULL) begin
                        r_baud <= '0;
                        if (w_rx) begin
                            // leave at mid stop bit so a back-to-back start edge is caught
                            r_state <= ST_IDLE;
                            if (!r_done && r_count < SIZE) begin
                                r_we    <= 1'b1;
                                r_addr  <= r_count[ADDR_W-1:0];
                                r_wdata <= r_shift;
                                r_count <= r_count + 1'b1;
`ifdef ICE51_LOADER_CSUM_EN
                                r_csum  <= r_csum + r_shift;
`endif
                            end
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (w_rx) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ice51_loader.sv
// tb_ice51_loader: directed self-checking bench for ice51_loader
module tb_ice51_loader;
    localparam int CPB = 8;
    localparam int MEM = 512;
    localparam int AW  = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [7:0]    o_mem_wdata;
    logic          o_load_done;
    logic          o_frame_err;
    logic [7:0]    o_csum;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [AW-1:0] wa_q[$];
    logic [7:0]    wd_q[$];
    int            ferr_cnt = 0;
    int            cyc = 0;
    int            last_we_cyc = 0;
    int            done_cyc = -1;
    logic [7:0]    img[MEM];
    logic [7:0]    sum;
    logic [7:0]    exp_csum;

    always #5 clk = ~clk;

    ice51_loader #(.CLKS_PER_BIT(CPB), .MEM_SIZE(MEM), .ADDR_W(AW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_uart_rx(rx),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_load_done(o_load_done),
        .o_frame_err(o_frame_err),
        .o_csum(o_csum)
    );

    always @(negedge clk) begin
        cyc++;
        if (o_mem_we) begin
            wa_q.push_back(o_mem_addr);
            wd_q.push_back(o_mem_wdata);
            last_we_cyc = cyc;
        end
        if (o_frame_err) ferr_cnt++;
        if (o_load_done && done_cyc < 0) done_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, o_mem_we, 0);
        check({tag, "_addr"}, o_mem_addr, 0);
        check({tag, "_wdata"}, o_mem_wdata, 0);
        check({tag, "_done"}, o_load_done, 0);
        check({tag, "_ferr"}, o_frame_err, 0);
        check({tag, "_csum"}, o_csum, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        send(8'h02, 1'b1);
        send(8'h00, 1'b1);
        send(8'h55, 1'b1);
        settle();
        check("t1_nwr", wa_q.size(), 3);
        check("t1_a0", wa_q[0], 0);
        check("t1_d0", wd_q[0], 8'h02);
        check("t1_a1", wa_q[1], 1);
        check("t1_d1", wd_q[1], 8'h00);
        check("t1_a2", wa_q[2], 2);
        check("t1_d2", wd_q[2], 8'h55);
        check("t1_done", o_load_done, 0);
        check("t1_ferr", ferr_cnt, 0);

        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_nwr", wa_q.size(), 3);
        send(8'h3C, 1'b1);
        settle();
        check("glitch_next_nwr", wa_q.size(), 4);
        check("glitch_next_a", wa_q[3], 3);
        check("glitch_next_d", wd_q[3], 8'h3C);

        send(8'hFF, 1'b0);
        repeat (3) bit_out(1'b0);
        bit_out(1'b1);
        send(8'h11, 1'b1);
        settle();
        check("ferr_cnt", ferr_cnt, 1);
        check("ferr_nwr", wa_q.size(), 5);
        check("ferr_next_a", wa_q[4], 4);
        check("ferr_next_d", wd_q[4], 8'h11);

        send(8'hA5, 1'b1);
        bit_out(1'b0);
        repeat (4) bit_out(1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_addr", o_mem_addr, 5);
        check("pre_rst_wdata", o_mem_wdata, 8'hA5);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        repeat (5 * CPB) @(negedge clk);
        check("midrst_nwr", wa_q.size(), 0);

        send(8'hF0, 1'b1);
        send(8'h20, 1'b1);
        send(8'h05, 1'b1);
        settle();
        check("cs_nwr", wa_q.size(), 3);
        check("cs_a0", wa_q[0], 0);
        check("cs_d0", wd_q[0], 8'hF0);
        check("cs_a2", wa_q[2], 2);
`ifdef ICE51_LOADER_CSUM_EN
        exp_csum = 8'h15;
`else
        exp_csum = 8'h00;
`endif
        check("cs_csum", o_csum, exp_csum);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wa_q.delete();
        wd_q.delete();
        done_cyc = -1;
        sum = 8'h00;
        for (int i = 0; i < MEM; i++) begin
            img[i] = 8'($urandom);
            sum = sum + img[i];
        end
        for (int i = 0; i < MEM; i++) send(img[i], 1'b1);
        settle();
        check("full_done", o_load_done, 1);
        check("full_done_lag", done_cyc - last_we_cyc, 1);
        send(8'hAA, 1'b1);
        settle();
        check("full_nwr", wa_q.size(), MEM);
        for (int i = 0; i < MEM && i < wa_q.size(); i++) begin
            check($sformatf("full_a%0d", i), wa_q[i], i);
            check($sformatf("full_d%0d", i), wd_q[i], img[i]);
        end
        check("full_hold_addr", o_mem_addr, MEM - 1);
        check("full_hold_wdata", o_mem_wdata, img[MEM-1]);
        check("full_done_sticky", o_load_done, 1);
        check("full_ferr", ferr_cnt, 1);
`ifdef ICE51_LOADER_CSUM_EN
        exp_csum = sum;
`else
        exp_csum = 8'h00;
`endif
        check("full_csum", o_csum, exp_csum);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ice51_loader.md
Name: ice51_loader

Overview:
- On-chip end of the ice51 program-load link.
- Receives 8N1 UART bytes on i_uart_rx, writes them sequentially into program memory from address 0, and raises o_load_done once MEM_SIZE bytes are stored.
- Sits between the top-level UART pin and the code RAM write port; o_load_done releases the core from hold.

Parameters:
CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200)
MEM_SIZE, 512, number of bytes to load before done
ADDR_W, 9, width of o_mem_addr; must satisfy 2**ADDR_W >= MEM_SIZE

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; synchronous and active-high; clock is i_clk (single clock domain)
i_uart_rx  in  1  asynchronous serial input; idle high
o_mem_we  out  1  one-cycle write strobe to program memory
o_mem_addr  out  ADDR_W  write address, valid while o_mem_we=1
o_mem_wdata  out  8  write data, valid while o_mem_we=1
o_load_done  out  1  high once MEM_SIZE bytes written; sticky until reset
o_frame_err  out  1  one-cycle pulse on stop-bit error
o_csum  out  8  running checksum (see Optional Feature)

Behaviour:
- Reset values: o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_load_done=0, o_frame_err=0, o_csum=0.
- Reset internal state: sync flops=1, state=IDLE, bit counter=0, baud counter=0, byte count=0.
- i_uart_rx passes through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
- IDLE: when rx_s=0, go to START and clear the baud counter.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then sample.
  - rx_s=1: glitch; return to IDLE with no side effects.
  - rx_s=0: go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After the 8th sample, go to STOP.
- STOP: wait CLKS_PER_BIT cycles, then sample.
  - rx_s=1: byte is good; go to IDLE.
  - rx_s=0: framing error; pulse o_frame_err for 1 cycle, discard the byte, go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. This prevents a held-low line from generating repeated bytes.
- Good byte, count < MEM_SIZE:
  - In the cycle after the stop sample: o_mem_we=1 for exactly 1 cycle, o_mem_addr=count, o_mem_wdata=byte.
  - count increments in that same cycle.
- o_load_done rises in the cycle after the write with count = MEM_SIZE-1, i.e. the cycle after the final o_mem_we.
- Good byte with o_load_done=1: ignored; no o_mem_we, no checksum update. The receiver keeps running.
- Latency: the o_mem_we pulse comes 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the start edge reaches i_uart_rx, ±1 cycle for sync phase.
- Back-to-back frames (stop bit directly followed by a start bit) must be accepted. Leaving STOP at mid-bit leaves half a bit of margin.
- Outside writes, o_mem_addr holds the last written address and o_mem_wdata holds the last written data.
- i_rst asserted mid-frame or mid-load: everything returns to the reset values above on the next clock edge. Loading restarts at address 0.

Optional Feature:
- Macro: ICE51_LOADER_CSUM_EN.
- Defined: o_csum = 8-bit modulo-256 sum of every byte actually written (o_mem_we=1).
  - Updates in the same cycle as the write and is cleared by reset.
  - Frozen once o_load_done=1.
- Not defined: o_csum is tied to 8'h00 and no adder is synthesized. The port exists in both builds.

Test Plan:
- Send bytes 0x02, 0x00, 0x55 at 115200 baud, 12 MHz clock, MEM_SIZE=512 -> three o_mem_we pulses: (addr 0, 0x02), (addr 1, 0x00), (addr 2, 0x55); o_load_done=0; o_frame_err never pulses.
- Send 512 random bytes back-to-back, then 0xAA -> 512 writes at addr 0..511 with matching data; o_load_done=1 after the 512th write; 0xAA produces no write.
- Drive a 1.5 µs low glitch on i_uart_rx while idle -> no write; state back in IDLE; a following 0x3C is written at the next address.
- Send a frame with stop bit=0 and data 0xFF, then hold the line low for 3 bit times, then send 0x11 -> one o_frame_err pulse, no write for 0xFF, 0x11 written at the current address.
- Assert i_rst for 1 cycle during bit 4 of the second byte -> all outputs are 0 on the next clock; the next byte is written at addr 0.
- With ICE51_LOADER_CSUM_EN defined, send 0xF0, 0x20, 0x05 -> o_csum=0x15. With it undefined, o_csum stays 0x00.
